// File: rtl/quantized_packer.sv
// Densely packs variable-width quantized values LSB-first into OUT_WIDTH-bit words.
// Push interface with no backpressure; a flush drains a partial word, deferring it by one cycle if a full word goes out first.
module quantized_packer #(
    parameter int MAX_BITWIDTH_QUANTIZED_DATA = 16,
    parameter int OUT_WIDTH                   = 32
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       value_rdy,
    input  logic [$clog2(MAX_BITWIDTH_QUANTIZED_DATA):0] bitwidth,
    input  logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0]     value,
    input  logic                                       flush,
    output logic                                       word_rdy,
    output logic [OUT_WIDTH-1:0]                       word,
    output logic [$clog2(OUT_WIDTH):0]                 word_bits,
    output logic [31:0]                                word_count,
    output logic                                       err,
    output logic [1:0]                                 fsm_state
);

    localparam int MAXW   = MAX_BITWIDTH_QUANTIZED_DATA;
    localparam int BW_W   = $clog2(MAXW) + 1;
    localparam int FILL_W = $clog2(OUT_WIDTH);
    localparam int WB_W   = FILL_W + 1;
    localparam int NW     = WB_W + 1;
    localparam int W2     = 2 * OUT_WIDTH;

    typedef enum logic [1:0] {
        S_EMPTY      = 2'd0,
        S_PARTIAL    = 2'd1,
        S_FLUSH_PEND = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic                 err_q, err_d;
    logic                 word_rdy_q;
    logic [OUT_WIDTH-1:0] word_q;
    logic [WB_W-1:0]      word_bits_q;
    logic [31:0]          word_count_q;

    logic                 legal, accept, emit, pend;
    logic [MAXW-1:0]      v_masked;
    logic [OUT_WIDTH-1:0] emit_word, base_acc, acc_new;
    logic [WB_W-1:0]      emit_bits;
    logic [FILL_W-1:0]    base_fill, fill_new;
    logic [NW-1:0]        n;
    logic [W2-1:0]        wide;

    assign legal    = (bitwidth != '0) && (bitwidth <= BW_W'(MAXW));
    assign accept   = value_rdy && legal;
    assign v_masked = value & ~({MAXW{1'b1}} << bitwidth);

    always_comb begin
        emit      = 1'b0;
        emit_word = '0;
        emit_bits = '0;
        pend      = 1'b0;
        err_d     = err_q | (value_rdy & ~legal);
        base_acc  = acc_q;
        base_fill = fill_q;
        // A deferred flush drains the leftover first; this cycle's value starts a fresh word.
        if (state_q == S_FLUSH_PEND) begin
            emit      = 1'b1;
            emit_word = acc_q;
            emit_bits = WB_W'(fill_q);
            base_acc  = '0;
            base_fill = '0;
        end
        n        = NW'(base_fill) + NW'(bitwidth);
        wide     = {{OUT_WIDTH{1'b0}}, base_acc} | (W2'(v_masked) << base_fill);
        acc_new  = base_acc;
        fill_new = base_fill;
        if (accept) begin
            if (n >= NW'(OUT_WIDTH)) begin
                emit      = 1'b1;
                emit_word = wide[OUT_WIDTH-1:0];
                emit_bits = WB_W'(OUT_WIDTH);
                acc_new   = wide[W2-1:OUT_WIDTH];
                fill_new  = FILL_W'(n - NW'(OUT_WIDTH));
            end else begin
                acc_new  = wide[OUT_WIDTH-1:0];
                fill_new = FILL_W'(n);
            end
        end
        if (flush && (fill_new != '0)) begin
            if (emit) begin
                pend = 1'b1;
            end else begin
                emit      = 1'b1;
                emit_word = acc_new;
                emit_bits = WB_W'(fill_new);
                acc_new   = '0;
                fill_new  = '0;
            end
        end
        acc_d   = acc_new;
        fill_d  = fill_new;
        state_d = pend ? S_FLUSH_PEND : ((fill_new == '0) ? S_EMPTY : S_PARTIAL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_EMPTY;
            acc_q        <= '0;
            fill_q       <= '0;
            err_q        <= 1'b0;
            word_rdy_q   <= 1'b0;
            word_q       <= '0;
            word_bits_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            err_q      <= err_d;
            word_rdy_q <= emit;
            if (emit) begin
                word_q       <= emit_word;
                word_bits_q  <= emit_bits;
                word_count_q <= word_count_q + 32'd1;
            end
        end
    end

    assign word_rdy   = word_rdy_q;
    assign word       = word_q;
    assign word_bits  = word_bits_q;
    assign word_count = word_count_q;
    assign err        = err_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_quantized_packer.sv
// Directed bench for quantized_packer: each task drives one scenario and checks outputs inline.
module tb_quantized_packer;

    logic        clk;
    logic        rst;
    logic        value_rdy;
    logic [4:0]  bitwidth;
    logic [15:0] value;
    logic        flush;
    logic        word_rdy;
    logic [31:0] word;
    logic [5:0]  word_bits;
    logic [31:0] word_count;
    logic        err;
    logic [1:0]  fsm_state;

    int n_vec = 0;
    int n_err = 0;

    quantized_packer #(
        .MAX_BITWIDTH_QUANTIZED_DATA(16),
        .OUT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value_rdy(value_rdy),
        .bitwidth(bitwidth),
        .value(value),
        .flush(flush),
        .word_rdy(word_rdy),
        .word(word),
        .word_bits(word_bits),
        .word_count(word_count),
        .err(err),
        .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; after return, outputs reflect the rising edge just passed.
    task automatic drive(input logic vr, input logic [4:0] bw, input logic [15:0] val, input logic fl);
        value_rdy = vr;
        bitwidth  = bw;
        value     = val;
        flush     = fl;
        @(negedge clk);
        value_rdy = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (word_rdy !== 1'b0) begin n_err++; $display("FAIL reset_word_rdy got %0b exp 0", word_rdy); end
        n_vec++; if (word !== 32'h0) begin n_err++; $display("FAIL reset_word got %h exp 0", word); end
        n_vec++; if (word_bits !== 6'd0) begin n_err++; $display("FAIL reset_word_bits got %0d exp 0", word_bits); end
        n_vec++; if (word_count !== 32'd0) begin n_err++; $display("FAIL reset_word_count got %0d exp 0", word_count); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %0b exp 0", err); end
        n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
    endtask

    task automatic test_full_word();
        logic [15:0] vals [4] = '{16'h11, 16'h22, 16'h33, 16'h44};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd8, vals[i], 1'b0);
            if (i < 3) begin
                n_vec++; if (word_rdy !== 1'b0) begin n_err++; $display("FAIL full_early_rdy i=%0d got %0b exp 0", i, word_rdy); end
            end
        end
        n_vec++; if (word_rdy !== 1'b1) begin n_err++; $display("FAIL full_rdy got %0b exp 1", word_rdy); end
        n_vec++; if (word !== 32'h44332211) begin n_err++; $display("FAIL full_word got %h exp 44332211", word); end
        n_vec++; if (word_bits !== 6'd32) begin n_err++; $display("FAIL full_bits got %0d exp 32", word_bits); end
        n_vec++; if (word_count !== 32'd1) begin n_err++; $display("FAIL full_count got %0d exp 1", word_count); end
        n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL full_state got %0d exp 0", fsm_state); end
        drive(1'b0, 5'd8, 16'h0, 1'b0);
        n_vec++; if (word_rdy !== 1'b0) begin n_err++; $display("FAIL full_pulse got %0b exp 0", word_rdy); end
        n_vec++; if (word !== 32'h44332211) begin n_err++; $display("FAIL full_hold got %h exp 44332211", word); end
    endtask

    task automatic test_straddle_flush();
        do_reset();
        drive(1'b1, 5'd12, 16'hABC, 1'b0);
        drive(1'b1, 5'd12, 16'h123, 1'b0);
        n_vec++; if (fsm_state !== 2'd1) begin n_err++; $display("FAIL strad_state got %0d exp 1", fsm_state); end
        drive(1'b1, 5'd12, 16'h456, 1'b0);
        n_vec++; if (word_rdy !== 1'b1) begin n_err++; $display("FAIL strad_rdy got %0b exp 1", word_rdy); end
        n_vec++; if (word !== 32'h56123ABC) begin n_err++; $display("FAIL strad_word got %h exp 56123abc", word); end
        n_vec++; if (word_bits !== 6'd32) begin n_err++; $display("FAIL strad_bits got %0d exp 32", word_bits); end
        drive(1'b0, 5'd12, 16'h0, 1'b1);
        n_vec++; if (word_rdy !== 1'b1) begin n_err++; $display("FAIL strad_flush_rdy got %0b exp 1", word_rdy); end
        n_vec++; if (word !== 32'h00000004) begin n_err++; $display("FAIL strad_flush_word got %h exp 00000004", word); end
        n_vec++; if (word_bits !== 6'd4) begin n_err++; $display("FAIL strad_flush_bits got %0d exp 4", word_bits); end
        n_vec++; if (word_count !== 32'd2) begin n_err++; $display("FAIL strad_count got %0d exp 2", word_count); end
        n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL strad_state_end got %0d exp 0", fsm_state); end
    endtask

    task automatic test_mask_illegal();
        do_reset();
        drive(1'b1, 5'd4, 16'hFFF5, 1'b0);
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mask_err_early got %0b exp 0", err); end
        drive(1'b1, 5'd0, 16'h0001, 1'b0);
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal0_err got %0b exp 1", err); end
        n_vec++; if (word_rdy !== 1'b0) begin n_err++; $display("FAIL illegal0_rdy got %0b exp 0", word_rdy); end
        drive(1'b0, 5'd0, 16'h0, 1'b1);
        n_vec++; if (word_rdy !== 1'b1) begin n_err++; $display("FAIL mask_rdy got %0b exp 1", word_rdy); end
        n_vec++; if (word !== 32'h00000005) begin n_err++; $display("FAIL mask_word got %h exp 00000005", word); end
        n_vec++; if (word_bits !== 6'd4) begin n_err++; $display("FAIL mask_bits got %0d exp 4", word_bits); end
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL mask_err_sticky got %0b exp 1", err); end
        // Width above MAX is dropped too, so the following flush finds nothing to emit.
        do_reset();
        drive(1'b1, 5'd17, 16'hFFFF, 1'b0);
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal17_err got %0b exp 1", err); end
        drive(1'b0, 5'd0, 16'h0, 1'b1);
        n_vec++; if (word_rdy !== 1'b0) begin n_err++; $display("FAIL illegal17_flush_rdy got %0b exp 0", word_rdy); end
    endtask

    task automatic test_simul_flush();
        do_reset();
        drive(1'b1, 5'd12, 16'hABC, 1'b0);
        drive(1'b1, 5'd12, 16'h123, 1'b0);
        drive(1'b1, 5'd12, 16'h456, 1'b1);
        n_vec++; if (word_rdy !== 1'b1) begin n_err++; $display("FAIL simul_rdy1 got %0b exp 1", word_rdy); end
        n_vec++; if (word !== 32'h56123ABC) begin n_err++; $display("FAIL simul_word1 got %h exp 56123abc", word); end
        n_vec++; if (fsm_state !== 2'd2) begin n_err++; $display("FAIL simul_pend_state got %0d exp 2", fsm_state); end
        drive(1'b0, 5'd0, 16'h0, 1'b0);
        n_vec++; if (word_rdy !== 1'b1) begin n_err++; $display("FAIL simul_rdy2 got %0b exp 1", word_rdy); end
        n_vec++; if (word !== 32'h00000004) begin n_err++; $display("FAIL simul_word2 got %h exp 00000004", word); end
        n_vec++; if (word_bits !== 6'd4) begin n_err++; $display("FAIL simul_bits2 got %0d exp 4", word_bits); end
        n_vec++; if (word_count !== 32'd2) begin n_err++; $display("FAIL simul_count got %0d exp 2", word_count); end
        drive(1'b0, 5'd0, 16'h0, 1'b0);
        n_vec++; if (word_rdy !== 1'b0) begin n_err++; $display("FAIL simul_extra_rdy got %0b exp 0", word_rdy); end
        n_vec++; if (word_count !== 32'd2) begin n_err++; $display("FAIL simul_count_end got %0d exp 2", word_count); end
    endtask

    task automatic test_back_to_back();
        // Value plus flush arriving in the deferred-flush cycle re-arms a second deferral.
        do_reset();
        drive(1'b1, 5'd12, 16'hABC, 1'b0);
        drive(1'b1, 5'd12, 16'h123, 1'b0);
        drive(1'b1, 5'd12, 16'h456, 1'b1);
        drive(1'b1, 5'd8, 16'hFF77, 1'b1);
        n_vec++; if (word !== 32'h00000004) begin n_err++; $display("FAIL b2b_left_word got %h exp 00000004", word); end
        n_vec++; if (fsm_state !== 2'd2) begin n_err++; $display("FAIL b2b_rearm_state got %0d exp 2", fsm_state); end
        drive(1'b0, 5'd0, 16'h0, 1'b0);
        n_vec++; if (word_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_rdy3 got %0b exp 1", word_rdy); end
        n_vec++; if (word !== 32'h00000077) begin n_err++; $display("FAIL b2b_word3 got %h exp 00000077", word); end
        n_vec++; if (word_bits !== 6'd8) begin n_err++; $display("FAIL b2b_bits3 got %0d exp 8", word_bits); end
        n_vec++; if (word_count !== 32'd3) begin n_err++; $display("FAIL b2b_count got %0d exp 3", word_count); end
    endtask

    task automatic test_empty_flush_reset();
        do_reset();
        drive(1'b0, 5'd0, 16'h0, 1'b1);
        n_vec++; if (word_rdy !== 1'b0) begin n_err++; $display("FAIL empty_flush_rdy got %0b exp 0", word_rdy); end
        drive(1'b1, 5'd8, 16'hA1, 1'b0);
        drive(1'b1, 5'd8, 16'hB2, 1'b0);
        drive(1'b1, 5'd8, 16'hC3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 16'h0, 1'b1);
        n_vec++; if (word_rdy !== 1'b0) begin n_err++; $display("FAIL midrst_rdy got %0b exp 0", word_rdy); end
        n_vec++; if (word !== 32'h0) begin n_err++; $display("FAIL midrst_word got %h exp 0", word); end
        n_vec++; if (word_bits !== 6'd0) begin n_err++; $display("FAIL midrst_bits got %0d exp 0", word_bits); end
        n_vec++; if (word_count !== 32'd0) begin n_err++; $display("FAIL midrst_count got %0d exp 0", word_count); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL midrst_err got %0b exp 0", err); end
    endtask

    task automatic test_stream();
        logic [15:0]  v3  [8] = '{16'h5, 16'h2, 16'h7, 16'h1, 16'h6, 16'h3, 16'h0, 16'h4};
        logic [15:0]  v13 [8] = '{16'h1ABC, 16'h0F0F, 16'h1234, 16'h0AAA, 16'h1555, 16'h1FFF, 16'h0001, 16'h1DEF};
        logic [127:0] stream;
        logic [31:0]  exp_q [$];
        logic [31:0]  exp_w;
        int           pos;
        int           got;
        stream = '0;
        pos    = 0;
        for (int i = 0; i < 8; i++) begin
            stream = stream | (128'(v3[i] & 16'h0007) << pos);
            pos    = pos + 3;
            stream = stream | (128'(v13[i] & 16'h1FFF) << pos);
            pos    = pos + 13;
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(stream[32*k +: 32]);
        do_reset();
        got = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1'b1, (i % 2 == 0) ? 5'd3 : 5'd13, (i % 2 == 0) ? v3[i/2] : v13[i/2], 1'b0);
            else        drive(1'b0, 5'd0, 16'h0, 1'b0);
            if (word_rdy === 1'b1) begin
                got++;
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                n_vec++; if (word !== exp_w) begin n_err++; $display("FAIL stream_word n=%0d got %h exp %h", got, word, exp_w); end
                n_vec++; if (word_bits !== 6'd32) begin n_err++; $display("FAIL stream_bits n=%0d got %0d exp 32", got, word_bits); end
            end
        end
        n_vec++; if (got != 4) begin n_err++; $display("FAIL stream_nwords got %0d exp 4", got); end
        n_vec++; if (word_count !== 32'd4) begin n_err++; $display("FAIL stream_count got %0d exp 4", word_count); end
        n_vec++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL stream_state got %0d exp 0", fsm_state); end
    endtask

    initial begin
        rst       = 1'b1;
        value_rdy = 1'b0;
        bitwidth  = '0;
        value     = '0;
        flush     = 1'b0;
        test_reset();
        test_full_word();
        test_straddle_flush();
        test_mask_illegal();
        test_simul_flush();
        test_back_to_back();
        test_empty_flush_reset();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/quantized_packer.md
# quantized_packer

Downstream stage of the quantization unit: takes each quantized integer (`result`/`result_rdy` pulse plus the active `bitwidth`) and densely packs its low `bitwidth` bits, LSB-first, into fixed-width output words for the memory write path. Values may straddle word boundaries and bitwidth may change per value. A flush command drains a partial word. Push-style interface with no backpressure, matching the upstream quantization unit.

## Interface
- `MAX_BITWIDTH_QUANTIZED_DATA`, default 16: width of the incoming value bus and the largest legal bitwidth.
- `OUT_WIDTH`, default 32: packed word width. Must be ≥ 2·`MAX_BITWIDTH_QUANTIZED_DATA`.
- `clk`, in, 1: the single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `value_rdy`, in, 1: one-cycle strobe; `value` and `bitwidth` are valid this cycle.
- `bitwidth`, in, `$clog2(MAX_BITWIDTH_QUANTIZED_DATA)+1`: number of valid LSBs of `value`. Legal range is 1..MAX.
- `value`, in, `MAX_BITWIDTH_QUANTIZED_DATA`: quantized value. Only bits `[bitwidth-1:0]` are used; upper bits are ignored.
- `flush`, in, 1: one-cycle strobe to emit any partial word, zero-padded.
- `word_rdy`, out, 1: one-cycle strobe; `word` and `word_bits` are valid.
- `word`, out, `OUT_WIDTH`: packed data. The first-packed bit is at bit 0.
- `word_bits`, out, `$clog2(OUT_WIDTH)+1`: number of meaningful bits in `word`. Equals `OUT_WIDTH` for a full word and is less for a flushed partial word.
- `word_count`, out, 32: total words emitted since reset. Wraps modulo 2^32.
- `err`, out, 1: sticky flag, set when an illegal bitwidth is seen. Cleared only by `rst`.

## Operation
- Internal state:
  - `acc` (`OUT_WIDTH` bits)
  - `fill` (0..`OUT_WIDTH`-1)
  - `flush_pend` (1 bit)
  - FSM with states EMPTY (`fill`=0), PARTIAL (`fill`>0), FLUSH_PEND.
- **Reset:** `acc`=0, `fill`=0, `flush_pend`=0, `word_rdy`=0, `word`=0, `word_bits`=0, `word_count`=0, `err`=0. State goes to EMPTY. Reset asserted mid-word discards the partial data; nothing is emitted.
- **Accepted value** (`value_rdy`, 1≤`bitwidth`≤MAX): let `v` = `value` masked to `bitwidth` bits, and `n` = `fill`+`bitwidth`.
  - `n` < `OUT_WIDTH`: `acc |= v<<fill`; `fill` = `n`.
  - `n` = `OUT_WIDTH`: emit `acc | v<<fill` with `word_bits`=`OUT_WIDTH`; `acc`=0, `fill`=0.
  - `n` > `OUT_WIDTH`: emit the low `OUT_WIDTH` bits of `acc | v<<fill`; `acc` = `v>>(OUT_WIDTH-fill)`; `fill` = `n-OUT_WIDTH`.
- **Illegal bitwidth** (0 or >MAX) with `value_rdy`: the value is dropped, `err` is set to 1, and state is unchanged.
- **Flush alone:**
  - `fill`>0: emit `acc` (upper bits zero) with `word_bits`=`fill`; `acc`=0, `fill`=0.
  - `fill`=0: no-op; no word is emitted.
- **Flush together with an accepted value:** the value is packed first, then the flush applies to the result.
  - If that cycle already emits a full word and leftover `fill`>0, set `flush_pend` (state FLUSH_PEND).
  - Otherwise, emit the combined partial word if its fill is >0.
- **FLUSH_PEND cycle:** emit the leftover bits with `word_bits`=leftover fill and clear `flush_pend`.
  - A value accepted in this same cycle is packed into a fresh accumulator at bit 0, after the flushed leftover.
  - A flush in this same cycle then applies to that fresh accumulator. If non-empty, it re-arms FLUSH_PEND.
- At most one word is emitted per cycle. With `OUT_WIDTH` ≥ 2·MAX this is always sufficient.
- `word_count` increments once per `word_rdy`, including partial words.

## Timing
- All outputs are registered.
- `word_rdy` pulses exactly 1 cycle after the `value_rdy` or `flush` edge that causes the emission. It is high for exactly one cycle.
- A deferred flush (FLUSH_PEND) emits 2 cycles after the flush edge.
- `word`, `word_bits` and `word_count` are updated on the same edge as `word_rdy`. `word` and `word_bits` hold their value until the next emission.
- `value_rdy` is accepted every cycle (throughput 1 value/cycle). There is no stall and no drop, except for illegal bitwidths.
- `err` rises 1 cycle after the offending `value_rdy`.

## Test plan
- **Full word, no straddle:** reset, then `bitwidth`=8 with values 0x11, 0x22, 0x33, 0x44 on consecutive cycles → one `word_rdy` 1 cycle after the 4th value, `word`=0x44332211, `word_bits`=32, `word_count`=1.
- **Straddle, then flush:** `bitwidth`=12, values 0xABC, 0x123, 0x456, then `flush` on the next cycle → `word`=0x56123ABC (`word_bits`=32), then `word`=0x00000004 (`word_bits`=4). `word_count`=2.
- **Masking and illegal width:** `bitwidth`=4, `value`=0xFFF5, then `bitwidth`=0 with `value`=0x1, then `flush` → `word`=0x00000005, `word_bits`=4, `err`=1.
- **Simultaneous flush:** `bitwidth`=12, 0xABC and 0x123 on consecutive cycles, then 0x456 with `flush` in the same cycle → 0x56123ABC one cycle later, 0x00000004 (`word_bits`=4) the cycle after. No other words.
- **Empty flush and mid-word reset:** `flush` with `fill`=0 produces no `word_rdy`. Pack 3 values at `bitwidth`=8, assert `rst` for 1 cycle, then `flush` → no word emitted, and all outputs read 0.
- **Mixed widths and streaming:** 16 back-to-back values alternating `bitwidth` 3 and 13 (values 0x5, 0x1ABC, ...) → compare against a scoreboard bit-stream model. Exactly 4 full words (128 bits) are emitted, with no gaps and no duplicates.
